// File: rtl/serial_parity_checker_if.sv
// Bit-stream and frame-result bundle for serial_parity_checker.
// err_count exists only when PARITY_ERR_CNT_EN is defined.
interface serial_parity_checker_if #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 8
);
    logic                 bit_valid;
    logic                 bit_in;
    logic                 sof;
    logic                 busy;
    logic                 frame_done;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data_out;

    if (DATA_BITS < 1 || DATA_BITS > 32 || CNT_W < 1) begin : g_bad_cfg
        $error("serial_parity_checker_if: unsupported DATA_BITS/CNT_W");
    end

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0]     err_count;

    modport master (
        output bit_valid, bit_in, sof,
        input  busy, frame_done, parity_err, data_out, err_count
    );
    modport slave (
        input  bit_valid, bit_in, sof,
        output busy, frame_done, parity_err, data_out, err_count
    );
`else
    modport master (
        output bit_valid, bit_in, sof,
        input  busy, frame_done, parity_err, data_out
    );
    modport slave (
        input  bit_valid, bit_in, sof,
        output busy, frame_done, parity_err, data_out
    );
`endif
endinterface

// File: rtl/serial_parity_checker.sv
// Framed serial parity checker: XOR-accumulates DATA_BITS LSB-first bits and checks a trailing parity bit.
// Optional saturating parity-error counter enabled by defining PARITY_ERR_CNT_EN.
module serial_parity_checker #(
    parameter int DATA_BITS = 8,
    parameter int ODD       = 0,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_parity_checker_if.slave   bus
);
    localparam int   CW      = $clog2(DATA_BITS + 1);
    localparam logic ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    if (DATA_BITS < 1 || DATA_BITS > 32 || CNT_W < 1) begin : g_bad_cfg
        $error("serial_parity_checker: unsupported DATA_BITS/CNT_W");
    end

    function automatic logic parity_step(input logic acc, input logic b);
        return acc ^ b;
    endfunction

    state_t               state_q, state_d;
    logic                 acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 parity_err_q, parity_err_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0]     err_count_q, err_count_d;
`endif

    logic                 err_s;
    logic [CW-1:0]        cnt_inc_s;
    logic [DATA_BITS-1:0] first_s;
    logic [DATA_BITS-1:0] shift_in_s;

    // Bits enter at the MSB so that after DATA_BITS shifts bit 0 lands at the LSB.
    assign err_s      = parity_step(parity_step(acc_q, bus.bit_in), ODD_BIT);
    assign cnt_inc_s  = cnt_q + CW'(1);
    assign first_s    = DATA_BITS'(bus.bit_in) << (DATA_BITS - 1);
    assign shift_in_s = (shift_q >> 1) | first_s;

    // Next-state and next-output logic; sof on any accepted bit restarts the frame.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;
        parity_err_d = parity_err_q;
        data_out_d   = data_out_q;
`ifdef PARITY_ERR_CNT_EN
        err_count_d  = err_count_q;
`endif
        if (bus.bit_valid) begin
            if (bus.sof) begin
                acc_d   = bus.bit_in;
                shift_d = first_s;
                cnt_d   = CW'(1);
                state_d = (DATA_BITS == 1) ? S_PARITY : S_DATA;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_d = S_IDLE;
                    end
                    S_DATA: begin
                        acc_d   = parity_step(acc_q, bus.bit_in);
                        shift_d = shift_in_s;
                        cnt_d   = cnt_inc_s;
                        if (cnt_inc_s == CW'(DATA_BITS)) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                    S_PARITY: begin
                        frame_done_d = 1'b1;
                        parity_err_d = err_s;
                        data_out_d   = shift_q;
                        state_d      = S_IDLE;
`ifdef PARITY_ERR_CNT_EN
                        if (err_s && (err_count_q != {CNT_W{1'b1}})) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end else begin
                            err_count_d = err_count_q;
                        end
`endif
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_q        <= 1'b0;
            cnt_q        <= {CW{1'b0}};
            shift_q      <= {DATA_BITS{1'b0}};
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            parity_err_q <= 1'b0;
            data_out_q   <= {DATA_BITS{1'b0}};
`ifdef PARITY_ERR_CNT_EN
            err_count_q  <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            parity_err_q <= parity_err_d;
            data_out_q   <= data_out_d;
`ifdef PARITY_ERR_CNT_EN
            err_count_q  <= err_count_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.parity_err = parity_err_q;
    assign bus.data_out   = data_out_q;
`ifdef PARITY_ERR_CNT_EN
    assign bus.err_count  = err_count_q;
`endif
endmodule
